// File: rtl/display_arbiter.sv
// display_arbiter: four-way round-robin owner arbitration for a shared quad
// seven-segment display. One owner at a time forwards its number (clamped to
// 9999) and dot enables. A contended owner is rotated out after a minimum
// dwell time, and two blank cycles separate consecutive owners.
//
// Handshake: req_i[n] is a level. It is held high for as long as requester n
// wants the display. gnt_o[n] high means requester n's slice is being shown.
// Dropping req_i[n] while granted releases the display. No per-transfer
// valid/ready exchange takes place.
module display_arbiter #(
    parameter int CLOCK_FREQ_HZ = 100_000_000,
    parameter int DWELL_MS      = 500
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  req_i,
    input  logic [55:0] num_i,
    input  logic [15:0] dots_i,
    output logic [3:0]  gnt_o,
    output logic        disp_en_o,
    output logic [13:0] disp_num_o,
    output logic [3:0]  dot_en_o,
    output logic [1:0]  state_dbg
);

    // The dwell length must be at least 2 cycles so that the counter has at
    // least one bit.
    localparam int DWELL_CYCLES = (CLOCK_FREQ_HZ / 1000) * DWELL_MS;
    localparam int DW           = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL_CYCLES - 1);
    localparam logic [13:0]   NUM_MAX   = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      owner;
    logic [1:0]      ptr;
    logic [DW-1:0]   dwell;

    logic [1:0]      pick;
    logic [13:0]     pick_num;
    logic [3:0]      pick_dots;
    logic [13:0]     owner_num;
    logic [3:0]      owner_dots;
    logic            owner_req;
    logic            other_req;

    // First asserted requester at or above ptr, wrapping 3 -> 0.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Clamp a 14-bit value to the four-digit display range.
    function automatic logic [13:0] clamp(input logic [13:0] v);
        clamp = (v > NUM_MAX) ? NUM_MAX : v;
    endfunction

    // Candidate owner in IDLE, and the current owner's slices in GRANT.
    always_comb begin
        pick       = rr_pick(req_i, ptr);
        pick_num   = clamp(num_i[int'(pick) * 14 +: 14]);
        pick_dots  = dots_i[int'(pick) * 4 +: 4];
        owner_num  = clamp(num_i[int'(owner) * 14 +: 14]);
        owner_dots = dots_i[int'(owner) * 4 +: 4];
        owner_req  = req_i[owner];
        other_req  = |(req_i & ~(4'b0001 << owner));
    end

    assign state_dbg = state;

    // Arbitration FSM with registered grant and display outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= 2'd0;
            ptr        <= 2'd0;
            dwell      <= '0;
            gnt_o      <= 4'b0000;
            disp_en_o  <= 1'b0;
            disp_num_o <= 14'd0;
            dot_en_o   <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i != 4'b0000) begin
                        state      <= GRANT;
                        owner      <= pick;
                        dwell      <= '0;
                        gnt_o      <= 4'b0001 << pick;
                        disp_en_o  <= 1'b1;
                        disp_num_o <= pick_num;
                        dot_en_o   <= pick_dots;
                    end
                end
                GRANT: begin
                    if (dwell != DWELL_MAX) begin
                        dwell <= dwell + 1'b1;
                    end
                    // Release wins over preemption; both lead to SWITCH.
                    if (!owner_req || (dwell == DWELL_MAX && other_req)) begin
                        state     <= SWITCH;
                        ptr       <= owner + 2'd1;
                        gnt_o     <= 4'b0000;
                        disp_en_o <= 1'b0;
                    end else begin
                        disp_num_o <= owner_num;
                        dot_en_o   <= owner_dots;
                    end
                end
                SWITCH: begin
                    // Requests are not looked at here; the next IDLE cycle decides.
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    gnt_o     <= 4'b0000;
                    disp_en_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_arbiter.sv
// Testbench for display_arbiter with a 4-cycle dwell (4 kHz clock, 1 ms).
module tb_display_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_SWITCH = 2'd2;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [55:0] num;
    logic [15:0] dots;
    logic [3:0]  gnt;
    logic        disp_en;
    logic [13:0] disp_num;
    logic [3:0]  dot_en;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    display_arbiter #(
        .CLOCK_FREQ_HZ(4000),
        .DWELL_MS     (1)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .req_i     (req),
        .num_i     (num),
        .dots_i    (dots),
        .gnt_o     (gnt),
        .disp_en_o (disp_en),
        .disp_num_o(disp_num),
        .dot_en_o  (dot_en),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic [55:0] num;
        logic [15:0] dots;
        logic [3:0]  gnt;
        logic        en;
        logic [13:0] dnum;
        logic [3:0]  ddots;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [55:0] pack_num(input int n0, input int n1, input int n2, input int n3);
        pack_num = {14'(n3), 14'(n2), 14'(n1), 14'(n0)};
    endfunction

    function automatic logic [15:0] pack_dots(input logic [3:0] d0, input logic [3:0] d1,
                                              input logic [3:0] d2, input logic [3:0] d3);
        pack_dots = {d3, d2, d1, d0};
    endfunction

    function automatic void add(input logic [3:0] r, input logic [55:0] n, input logic [15:0] d,
                                input logic [3:0] g, input logic e, input int dn,
                                input logic [3:0] dd, input logic [1:0] s);
        vec_t v;
        v.req = r; v.num = n; v.dots = d;
        v.gnt = g; v.en = e; v.dnum = 14'(dn); v.ddots = dd; v.st = s;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic e,
                           input logic [13:0] dn, input logic [3:0] dd, input logic [1:0] s);
        chk({tag, ".gnt"},      32'(gnt),       32'(g));
        chk({tag, ".disp_en"},  32'(disp_en),   32'(e));
        chk({tag, ".disp_num"}, 32'(disp_num),  32'(dn));
        chk({tag, ".dot_en"},   32'(dot_en),    32'(dd));
        chk({tag, ".state"},    32'(state_dbg), 32'(s));
    endtask

    // Drive inputs away from the edge, then sample just after the next edge.
    task automatic step(input logic [3:0] r, input logic [55:0] n, input logic [15:0] d);
        @(negedge clk);
        req  = r;
        num  = n;
        dots = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [55:0] n_base;
        logic [15:0] d_base;
        logic [55:0] n_rr;
        logic [15:0] d_rr;
        logic [3:0]  exp_g;

        n_base = pack_num(42, 777, 1234, 5555);
        d_base = pack_dots(4'b0001, 4'b0100, 4'b0010, 4'b1000);
        n_rr   = pack_num(10, 20, 30, 40);
        d_rr   = pack_dots(4'b0001, 4'b0010, 4'b0100, 4'b1000);

        // ---- vector table ----
        // single requester 2: 1-cycle latency, then held with no rotation
        for (int i = 0; i < 23; i++)
            add(4'b0100, n_base, d_base, 4'b0100, 1'b1, 1234, 4'b0010, S_GRANT);
        // saturation and tracking on owner 2
        add(4'b0100, pack_num(42, 777, 9998, 5555), d_base, 4'b0100, 1'b1, 9998, 4'b0010, S_GRANT);
        add(4'b0100, pack_num(42, 777, 10000, 5555), d_base, 4'b0100, 1'b1, 9999, 4'b0010, S_GRANT);
        add(4'b0100, pack_num(42, 777, 16383, 5555), d_base, 4'b0100, 1'b1, 9999, 4'b0010, S_GRANT);
        // release by owner 2 -> SWITCH (ptr=3); display values hold
        add(4'b0000, pack_num(42, 777, 16383, 5555), d_base, 4'b0000, 1'b0, 9999, 4'b0010, S_SWITCH);
        // req 0 raised during SWITCH is only seen in IDLE
        add(4'b0001, n_base, d_base, 4'b0000, 1'b0, 9999, 4'b0010, S_IDLE);
        // wrap from ptr=3 to requester 0
        add(4'b0001, n_base, d_base, 4'b0001, 1'b1, 42, 4'b0001, S_GRANT);
        // release by owner 0 -> ptr=1, then idle with no requests
        add(4'b0000, n_base, d_base, 4'b0000, 1'b0, 42, 4'b0001, S_SWITCH);
        add(4'b0000, n_base, d_base, 4'b0000, 1'b0, 42, 4'b0001, S_IDLE);
        add(4'b0000, n_base, d_base, 4'b0000, 1'b0, 42, 4'b0001, S_IDLE);
        // early release: owner 1 for 2 cycles, then drops while 3 pends
        add(4'b1010, n_base, d_base, 4'b0010, 1'b1, 777, 4'b0100, S_GRANT);
        add(4'b1010, n_base, d_base, 4'b0010, 1'b1, 777, 4'b0100, S_GRANT);
        add(4'b1000, n_base, d_base, 4'b0000, 1'b0, 777, 4'b0100, S_SWITCH);
        add(4'b1000, n_base, d_base, 4'b0000, 1'b0, 777, 4'b0100, S_IDLE);
        add(4'b1000, n_base, d_base, 4'b1000, 1'b1, 5555, 4'b1000, S_GRANT);

        // ---- reset block ----
        rst_n = 1'b0;
        req   = 4'b0000;
        num   = '0;
        dots  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", 4'b0000, 1'b0, 14'd0, 4'b0000, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].num, vecs[i].dots);
            chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].en, vecs[i].dnum,
                    vecs[i].ddots, vecs[i].st);
        end

        // ---- contention: release 3 (ptr=0), then req=1111 rotates 0,1,2,3,0 ----
        step(4'b0000, n_rr, d_rr);
        chk("rr_pre.state", 32'(state_dbg), 32'(S_SWITCH));
        step(4'b1111, n_rr, d_rr);
        chk("rr_pre_idle.state", 32'(state_dbg), 32'(S_IDLE));
        chk("rr_pre_idle.gnt", 32'(gnt), 32'(0));
        for (int r = 0; r < 5; r++) begin
            exp_g = 4'b0001 << (r % 4);
            for (int c = 0; c < 4; c++) begin
                step(4'b1111, n_rr, d_rr);
                chk($sformatf("rr%0d_c%0d.gnt", r, c), 32'(gnt), 32'(exp_g));
                chk($sformatf("rr%0d_c%0d.en", r, c), 32'(disp_en), 32'(1));
                chk($sformatf("rr%0d_c%0d.num", r, c), 32'(disp_num), 32'(10 * ((r % 4) + 1)));
            end
            if (r < 4) begin
                for (int c = 0; c < 2; c++) begin
                    step(4'b1111, n_rr, d_rr);
                    chk($sformatf("rr%0d_gap%0d.gnt", r, c), 32'(gnt), 32'(0));
                    chk($sformatf("rr%0d_gap%0d.en", r, c), 32'(disp_en), 32'(0));
                end
            end
        end

        // ---- set ptr=2 and grant requester 1 by wrapping ----
        step(4'b0010, n_base, d_base);   // owner 0 drops -> SWITCH, ptr=1
        step(4'b0010, n_base, d_base);   // IDLE
        step(4'b0010, n_base, d_base);   // grant 1
        chk("pre_rst_a.gnt", 32'(gnt), 32'(4'b0010));
        step(4'b0000, n_base, d_base);   // owner 1 drops -> SWITCH, ptr=2
        step(4'b0010, n_base, d_base);   // IDLE
        step(4'b0010, n_base, d_base);   // grant 1 via 2,3,0,1
        chk_out("pre_rst_b", 4'b0010, 1'b1, 14'd777, 4'b0100, S_GRANT);

        // ---- reset mid-grant: asynchronous clear, then arbitration from ptr=0 ----
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 1'b0, 14'd0, 4'b0000, S_IDLE);
        @(posedge clk);
        #1;
        chk_out("rst_held", 4'b0000, 1'b0, 14'd0, 4'b0000, S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        #1;
        chk("rst_release.gnt", 32'(gnt), 32'(0));
        @(posedge clk);
        #1;
        chk_out("post_rst", 4'b0010, 1'b1, 14'd777, 4'b0100, S_GRANT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The block SHALL have parameter CLOCK_FREQ_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter DWELL_MS, default 500, meaning the minimum ownership time in ms before a contended grant rotates.
REQ-003 The block SHALL derive DWELL_CYCLES = (CLOCK_FREQ_HZ/1000)*DWELL_MS, which SHALL be >= 2, and a dwell counter of width $clog2(DWELL_CYCLES).
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_i, input, 4 bits: per-requester display request, level-held while the requester wants the display.
REQ-007 The block SHALL have port num_i, input, 56 bits: four packed 14-bit values, requester n at bits [14n+13:14n].
REQ-008 The block SHALL have port dots_i, input, 16 bits: four packed 4-bit dot enables, requester n at bits [4n+3:4n].
REQ-009 The block SHALL have port gnt_o, output, 4 bits: one-hot or zero grant, registered.
REQ-010 The block SHALL have port disp_en_o, output, 1 bit: display enable for the quad display driver.
REQ-011 The block SHALL have port disp_num_o, output, 14 bits: the number forwarded to the display driver.
REQ-012 The block SHALL have port dot_en_o, output, 4 bits: the dot enables forwarded to the display driver.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and SWITCH, and SHALL hold a 2-bit owner register and a 2-bit round-robin pointer ptr.
REQ-014 In IDLE with req_i != 0 at a clock edge, the FSM SHALL select the first asserted requester at or above ptr (wrapping 3->0), load owner, clear the dwell counter, and enter GRANT on that edge.
REQ-015 In IDLE with req_i == 0, the FSM SHALL remain in IDLE.
REQ-016 Grant latency SHALL be exactly 1 cycle: gnt_o, disp_en_o and the first valid disp_num_o SHALL appear in the cycle after the edge at which req_i was sampled in IDLE.
REQ-017 In GRANT, gnt_o SHALL equal 1<<owner and disp_en_o SHALL be 1, and disp_num_o and dot_en_o SHALL be re-registered every cycle from the owner's slice (1-cycle lag).
REQ-018 disp_num_o SHALL saturate: an owner slice value > 9999 SHALL be output as 9999.
REQ-019 In GRANT, the dwell counter SHALL increment each cycle and saturate at DWELL_CYCLES-1.
REQ-020 In GRANT, if req_i[owner]==0, the FSM SHALL enter SWITCH immediately, regardless of the dwell count.
REQ-021 In GRANT, if the dwell counter == DWELL_CYCLES-1 and any other req_i bit is 1, the FSM SHALL enter SWITCH (preemption).
REQ-022 In GRANT, if the dwell counter is saturated and no other request is pending, the FSM SHALL stay in GRANT indefinitely.
REQ-023 If release (REQ-020) and preemption (REQ-021) conditions coincide, release SHALL take precedence, with identical next state.
REQ-024 On each entry to SWITCH, ptr SHALL be set to owner+1 (mod 4).
REQ-025 SWITCH SHALL last exactly one cycle, with gnt_o=0 and disp_en_o=0, and SHALL then go to IDLE, giving a minimum 2-cycle blank gap between owners.
REQ-026 In IDLE and SWITCH, disp_num_o and dot_en_o SHALL hold their last values.
REQ-027 Requests that assert or deassert during SWITCH SHALL be evaluated only in the following IDLE cycle.
REQ-028 A requester that drops and re-asserts its request SHALL receive no priority; fairness SHALL come only from ptr.

Reset
REQ-029 While rst_ni==0, asynchronously: state=IDLE, owner=0, ptr=0, dwell=0, gnt_o=4'b0000, disp_en_o=0, disp_num_o=0, dot_en_o=4'b0000.
REQ-030 Reset asserted during GRANT or SWITCH SHALL abort immediately to the REQ-029 values, and the first post-reset arbitration SHALL start from ptr=0.
REQ-031 Release of rst_ni SHALL be sampled synchronously; the first state change SHALL occur no earlier than the first rising edge with rst_ni==1.

Verification (bench: CLOCK_FREQ_HZ=4000, DWELL_MS=1 -> DWELL_CYCLES=4)
REQ-032 Single requester: req_i=4'b0100 with slice2=1234 and dots2=4'b0010 -> gnt_o=4'b0100, disp_en_o=1, disp_num_o=1234 and dot_en_o=4'b0010 one cycle later, held for 20+ cycles with no rotation.
REQ-033 Contention: req_i=4'b1111 held -> grants rotate 0,1,2,3,0, each held 4 cycles, separated by 2 cycles with gnt_o=0 and disp_en_o=0.
REQ-034 Early release: owner 1 drops its request after 2 cycles while req 3 is pending -> SWITCH on the next edge, then gnt_o=4'b1000 after IDLE, and ptr skips 2 because req 2 is low.
REQ-035 Saturation and tracking: owner slice changes 9998->10000->16383 -> disp_num_o shows 9998, 9999, 9999, each with 1-cycle lag.
REQ-036 Reset mid-grant: rst_ni pulsed low for 1 cycle while gnt_o=4'b0010 -> all outputs zero asynchronously, and with req_i=4'b1010 after release the next grant is 4'b0010 (ptr=0).
REQ-037 Wrap: ptr=3 with req_i=4'b0001 -> gnt_o=4'b0001, proving the 3->0 wrap.
